// File: rtl/dvfs_seq_pkg.sv
// Shared types, default widths and helpers for the DVFS LDO sequencer.
package dvfs_seq_pkg;

    localparam int CODE_W_DEF   = 8;
    localparam int SETTLE_W_DEF = 12;

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        SETTLE_UP,
        FREQ_UP,
        FREQ_DN,
        SETTLE_DN,
        RAMP_DN
    } seq_state_t;

    // a + b, clamped to max_val; one extra bit holds the carry so nothing wraps
    function automatic logic [15:0] sat_add(input logic [15:0] a,
                                            input logic [15:0] b,
                                            input logic [15:0] max_val);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[15:0];
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Settle dwell timer: loadable down-counter that stops at zero and flags it.
module settle_timer
    import dvfs_seq_pkg::*;
#(
    parameter int WIDTH = SETTLE_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // load wins over decrement; the count parks at zero
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dvfs_ldo_sequencer.sv
// DVFS LDO sequencer: turns a frequency target into slew-limited LDO and
// clock code updates, voltage leading on the way up and trailing on the way down.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for freq_target != freq_code; latches tgt / vtgt
//   RAMP_UP   | raise ldo_code one step toward vtgt, or move on to FREQ_UP
//   SETTLE_UP | dwell settle_cycles+1 cycles after an upward voltage step
//   FREQ_UP   | apply the new (higher) frequency code, pulse done
//   FREQ_DN   | apply the new (lower) frequency code before touching voltage
//   SETTLE_DN | dwell settle_cycles+1 cycles after a downward change
//   RAMP_DN   | lower ldo_code one step toward vtgt, or finish with done
module dvfs_ldo_sequencer
    import dvfs_seq_pkg::*;
#(
    parameter int CODE_W   = CODE_W_DEF,
    parameter int SETTLE_W = SETTLE_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [CODE_W-1:0]   freq_target,
    input  logic [3:0]          step_size,
    input  logic [SETTLE_W-1:0] settle_cycles,
    input  logic [3:0]          v_guard,
    output logic [CODE_W-1:0]   ldo_code,
    output logic [CODE_W-1:0]   freq_code,
    output logic                busy,
    output logic                done
);

    localparam logic [CODE_W-1:0] CODE_MAX = '1;

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [CODE_W-1:0] tgt;
    logic [CODE_W-1:0] tgt_nxt;
    logic [CODE_W-1:0] vtgt;
    logic [CODE_W-1:0] vtgt_nxt;
    logic [CODE_W-1:0] ldo_nxt;
    logic [CODE_W-1:0] freq_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              timer_load;
    logic              timer_en;
    logic              timer_zero;
    logic [CODE_W:0]   step_ext;
    logic [CODE_W:0]   up_sum;
    logic [CODE_W:0]   dn_diff;

    // a zero step would stall the ramp forever, so it behaves as one
    assign step_ext = (step_size == 4'd0) ? (CODE_W+1)'(1) : (CODE_W+1)'(step_size);
    assign up_sum   = {1'b0, ldo_code} + step_ext;
    assign dn_diff  = {1'b0, ldo_code} - step_ext;

    settle_timer #(
        .WIDTH (SETTLE_W)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .en         (timer_en),
        .load_value (settle_cycles),
        .zero       (timer_zero)
    );

    // next-state and next-output decode; enable low holds everything
    always_comb begin
        state_nxt  = state;
        tgt_nxt    = tgt;
        vtgt_nxt   = vtgt;
        ldo_nxt    = ldo_code;
        freq_nxt   = freq_code;
        done_nxt   = 1'b0;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        if (enable) begin
            unique case (state)
                IDLE: begin
                    if (freq_target != freq_code) begin
                        tgt_nxt   = freq_target;
                        vtgt_nxt  = CODE_W'(sat_add(16'(freq_target), 16'(v_guard), 16'(CODE_MAX)));
                        state_nxt = (freq_target > freq_code) ? RAMP_UP : FREQ_DN;
                    end
                end
                RAMP_UP: begin
                    if (ldo_code < vtgt) begin
                        ldo_nxt    = (up_sum > {1'b0, vtgt}) ? vtgt : up_sum[CODE_W-1:0];
                        timer_load = 1'b1;
                        state_nxt  = SETTLE_UP;
                    end else begin
                        state_nxt = FREQ_UP;
                    end
                end
                SETTLE_UP: begin
                    if (timer_zero) begin
                        state_nxt = RAMP_UP;
                    end else begin
                        timer_en = 1'b1;
                    end
                end
                FREQ_UP: begin
                    freq_nxt  = tgt;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
                FREQ_DN: begin
                    freq_nxt   = tgt;
                    timer_load = 1'b1;
                    state_nxt  = SETTLE_DN;
                end
                SETTLE_DN: begin
                    if (timer_zero) begin
                        state_nxt = RAMP_DN;
                    end else begin
                        timer_en = 1'b1;
                    end
                end
                RAMP_DN: begin
                    if (ldo_code > vtgt) begin
                        ldo_nxt    = (dn_diff[CODE_W] || (dn_diff < {1'b0, vtgt})) ?
                                     vtgt : dn_diff[CODE_W-1:0];
                        timer_load = 1'b1;
                        state_nxt  = SETTLE_DN;
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
        busy_nxt = (state_nxt != IDLE);
    end

    // state, latched targets and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            tgt       <= '0;
            vtgt      <= '0;
            ldo_code  <= '0;
            freq_code <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            tgt       <= tgt_nxt;
            vtgt      <= vtgt_nxt;
            ldo_code  <= ldo_nxt;
            freq_code <= freq_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_dvfs_ldo_sequencer.sv
// Bench for dvfs_ldo_sequencer: directed scenarios plus random traffic, all
// checked cycle by cycle against a timeline model of each sequence.
module tb_dvfs_ldo_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  freq_target;
    logic [3:0]  step_size;
    logic [11:0] settle_cycles;
    logic [3:0]  v_guard;
    logic [7:0]  ldo_code;
    logic [7:0]  freq_code;
    logic        busy;
    logic        done;

    dvfs_ldo_sequencer #(
        .CODE_W   (8),
        .SETTLE_W (12)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .freq_target   (freq_target),
        .step_size     (step_size),
        .settle_cycles (settle_cycles),
        .v_guard       (v_guard),
        .ldo_code      (ldo_code),
        .freq_code     (freq_code),
        .busy          (busy),
        .done          (done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] ldo;
        logic [7:0] freq;
        logic       busy;
        logic       done;
    } snap_t;

    snap_t      m = '0;
    snap_t      exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] last_freq = '0;

    int ch_val[$];
    int ch_idx[$];
    int want[$];
    int done_edge;
    int freq_edge;
    int ldo_at_freq;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic snap_t mk(input int l, input int f, input bit b, input bit d);
        snap_t r;
        r.ldo  = 8'(l);
        r.freq = 8'(f);
        r.busy = b;
        r.done = d;
        return r;
    endfunction

    task automatic push_hold(input snap_t s, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(s);
    endtask

    // expected outputs after every enabled edge of one sequence, latch edge first
    task automatic gen_seq();
        int t, vt, l, f, s, dwell;
        t  = int'(freq_target);
        vt = t + int'(v_guard);
        if (vt > 255) vt = 255;
        s     = (step_size == 4'd0) ? 1 : int'(step_size);
        dwell = int'(settle_cycles) + 1;
        l = int'(m.ldo);
        f = int'(m.freq);
        exp_q.push_back(mk(l, f, 1'b1, 1'b0));
        if (t > f) begin
            while (l < vt) begin
                l = (l + s > vt) ? vt : l + s;
                push_hold(mk(l, f, 1'b1, 1'b0), 1 + dwell);
            end
            exp_q.push_back(mk(l, f, 1'b1, 1'b0));
            exp_q.push_back(mk(l, t, 1'b0, 1'b1));
        end else begin
            f = t;
            push_hold(mk(l, f, 1'b1, 1'b0), 1 + dwell);
            while (l > vt) begin
                l = (l - s < vt) ? vt : l - s;
                push_hold(mk(l, f, 1'b1, 1'b0), 1 + dwell);
            end
            exp_q.push_back(mk(l, f, 1'b0, 1'b1));
        end
    endtask

    task automatic tick();
        int need;
        @(posedge clock);
        if (reset) begin
            exp_q.delete();
            m = '0;
        end else if (!enable) begin
            m.done = 1'b0;
        end else begin
            if ((exp_q.size() == 0) && (freq_target != m.freq)) gen_seq();
            if (exp_q.size() != 0) begin
                m = exp_q.pop_front();
            end else begin
                m.busy = 1'b0;
                m.done = 1'b0;
            end
        end
        #1;
        check_val("ldo_code",  ldo_code,  m.ldo);
        check_val("freq_code", freq_code, m.freq);
        check_val("busy",      busy,      m.busy);
        check_val("done",      done,      m.done);
        if (!reset && (freq_code > last_freq)) begin
            need = int'(freq_code) + int'(v_guard);
            if (need > 255) need = 255;
            check_val("volt_before_freq", (int'(ldo_code) >= need), 1);
        end
        last_freq = freq_code;
    endtask

    // latch edge, then up to budget edges until done; records ldo/freq changes
    task automatic run_seq(input int budget, input int freeze_at, input int freeze_len,
                           input int chg_at, input logic [7:0] chg_val);
        logic [7:0] pl, pf;
        ch_val.delete();
        ch_idx.delete();
        done_edge   = -1;
        freq_edge   = -1;
        ldo_at_freq = -1;
        pl = ldo_code;
        pf = freq_code;
        tick();
        check_val("latch_busy", busy, 1);
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (ldo_code != pl) begin
                ch_val.push_back(int'(ldo_code));
                ch_idx.push_back(i);
                pl = ldo_code;
            end
            if (freq_code != pf) begin
                freq_edge   = i;
                ldo_at_freq = int'(ldo_code);
                pf          = freq_code;
            end
            if (done) begin
                done_edge = i;
                break;
            end
            if (i == chg_at) freq_target = chg_val;
            if (i == freeze_at) enable = 1'b0;
            if (i == freeze_at + freeze_len) enable = 1'b1;
        end
        check_val("seq_done_in_budget", (done_edge >= 0), 1);
    endtask

    task automatic check_hist(input string tag);
        check_val({tag, "_count"}, ch_val.size(), want.size());
        for (int k = 0; k < want.size(); k++)
            check_val(tag, (k < ch_val.size()) ? ch_val[k] : -1, want[k]);
    endtask

    initial begin
        int n_done;
        bit step_ok;

        reset = 1'b1; enable = 1'b0; freq_target = '0;
        step_size = 4'd4; settle_cycles = 12'd3; v_guard = 4'd2;
        tick();
        tick();
        check_val("reset_ldo", ldo_code, 0);
        check_val("reset_busy", busy, 0);
        reset = 1'b0;

        // basic ramp up to 10: vtgt 12, ldo 4/8/12 each held 5 cycles
        enable = 1'b1; freq_target = 8'd10;
        run_seq(60, -1, 0, -1, 8'd0);
        want = '{4, 8, 12};
        check_hist("up_ldo_steps");
        check_val("up_hold0", (ch_idx.size() > 1) ? ch_idx[1] - ch_idx[0] : -1, 5);
        check_val("up_hold1", (ch_idx.size() > 2) ? ch_idx[2] - ch_idx[1] : -1, 5);
        check_val("up_done_edge", done_edge, 17);
        check_val("up_freq", freq_code, 10);
        tick();
        check_val("up_busy_fall", busy, 0);

        // ramp down to 3: frequency first, then ldo 8 and clamped 5
        freq_target = 8'd3; settle_cycles = 12'd0;
        run_seq(60, -1, 0, -1, 8'd0);
        check_val("dn_freq_edge", freq_edge, 1);
        check_val("dn_ldo_at_freq", ldo_at_freq, 12);
        want = '{8, 5};
        check_hist("dn_ldo_steps");
        check_val("dn_done_edge", done_edge, 7);
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) n_done++;
        end
        check_val("dn_done_once", n_done, 0);

        // target moves 10 -> 20 while settling; first run still ends at 10
        freq_target = 8'd10; settle_cycles = 12'd3;
        run_seq(60, -1, 0, 2, 8'd20);
        check_val("chg_first_freq", freq_code, 10);
        check_val("chg_first_edge", done_edge, 12);
        run_seq(60, -1, 0, -1, 8'd0);
        check_val("chg_second_freq", freq_code, 20);
        want = '{16, 20, 22};
        check_hist("chg_second_steps");

        // enable low for 7 edges inside the first settle stretches it by 7
        freq_target = 8'd30;
        run_seq(80, 2, 7, -1, 8'd0);
        check_val("frz_done_edge", done_edge, 24);
        check_val("frz_hold0", (ch_idx.size() > 1) ? ch_idx[1] - ch_idx[0] : -1, 12);
        check_val("frz_freq", freq_code, 30);

        // saturation: vtgt clamps at 255, step 0 moves by 1
        v_guard = 4'd15; step_size = 4'd0; settle_cycles = 12'd0; freq_target = 8'd250;
        run_seq(700, -1, 0, -1, 8'd0);
        step_ok = (ch_val.size() > 0) && (ch_val[0] == 33);
        for (int k = 1; k < ch_val.size(); k++)
            if (ch_val[k] != ch_val[k-1] + 1) step_ok = 1'b0;
        check_val("sat_step_one", step_ok, 1);
        check_val("sat_ldo_final", ldo_code, 255);
        check_val("sat_ldo_at_freq", ldo_at_freq, 255);
        check_val("sat_freq_at_done", freq_edge, done_edge);
        check_val("sat_freq", freq_code, 250);

        // reset while in RAMP_DN aborts to zero with no done
        v_guard = 4'd2; step_size = 4'd4; settle_cycles = 12'd1; freq_target = 8'd100;
        for (int i = 0; i < 7; i++) tick();
        check_val("rst_pre_ldo", ldo_code, 251);
        reset = 1'b1;
        tick();
        check_val("rst_ldo", ldo_code, 0);
        check_val("rst_freq", freq_code, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        reset = 1'b0; enable = 1'b0;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) n_done++;
        end
        check_val("rst_no_done", n_done, 0);

        // random traffic
        enable = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if ((exp_q.size() == 0) && !m.busy && ($urandom_range(0, 3) == 0)) begin
                step_size     = 4'($urandom_range(0, 15));
                v_guard       = 4'($urandom_range(0, 15));
                settle_cycles = 12'($urandom_range(0, 4));
            end
            if ($urandom_range(0, 19) == 0) freq_target = 8'($urandom_range(0, 255));
            enable = ($urandom_range(0, 9) != 0);
            reset  = ($urandom_range(0, 799) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dvfs_ldo_sequencer.md
Name: dvfs_ldo_sequencer

Overview:
- Sits directly downstream of the token-exchange FSM in each DVFS tile socket and consumes its 8-bit freq_target.
- Turns each new target into a safe, slew-limited sequence of LDO voltage codes and clock-frequency codes.
- Raising frequency: voltage ramps up first, then frequency changes.
- Lowering frequency: frequency drops first, then voltage ramps down.
- Every voltage step is followed by a programmable settle interval.

Parameters:
- CODE_W, 8: width of freq_target, freq_code and ldo_code.
- SETTLE_W, 12: width of the settle counter and of settle_cycles.

Ports:
- clock  in  1  NoC/tile clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  sequencer runs when 1; holds all state when 0.
- freq_target  in  CODE_W  requested frequency code from the token FSM.
- step_size  in  4  maximum ldo_code change per step; 0 is treated as 1.
- settle_cycles  in  SETTLE_W  dwell after each voltage step, minus one.
- v_guard  in  4  voltage-code margin added to the target code.
- ldo_code  out  CODE_W  registered code to the LDO.
- freq_code  out  CODE_W  registered code to the clock generator.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when a transition completes.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - On reset: ldo_code=0, freq_code=0, busy=0, done=0, state=IDLE, settle counter=0, latched targets=0.
  - Reset asserted mid-sequence aborts the sequence immediately to the reset values.
- States: IDLE, RAMP_UP, SETTLE_UP, FREQ_UP, FREQ_DN, SETTLE_DN, RAMP_DN.
- IDLE:
  - Starts a sequence when enable=1 and freq_target!=freq_code.
  - On start, latch tgt=freq_target and vtgt=min(tgt+v_guard, 2^CODE_W-1), saturating.
  - Next state is RAMP_UP if tgt>freq_code, otherwise FREQ_DN.
  - freq_target is sampled only in IDLE; changes during a sequence take effect after done.
- RAMP_UP:
  - If ldo_code<vtgt: ldo_code<=min(ldo_code+step, vtgt), then go to SETTLE_UP.
  - Otherwise go to FREQ_UP; a higher existing ldo_code is left unchanged.
- SETTLE_UP and SETTLE_DN:
  - The counter loads settle_cycles on entry and decrements each cycle.
  - The state exits when the counter is 0, so dwell is settle_cycles+1 cycles; settle_cycles=0 gives 1 cycle.
  - SETTLE_UP returns to RAMP_UP. SETTLE_DN goes to RAMP_DN.
- FREQ_UP: freq_code<=tgt and done<=1 on the same edge, then IDLE.
- FREQ_DN: freq_code<=tgt, then SETTLE_DN.
- RAMP_DN:
  - If ldo_code>vtgt: ldo_code<=max(ldo_code-step, vtgt), then go to SETTLE_DN.
  - Otherwise done<=1, then IDLE; a lower existing ldo_code is left unchanged.
- Arithmetic: step arithmetic uses CODE_W+1 bits, then clamps to vtgt, so there is no wrap at 0 or 255.
- Outputs:
  - done is high for exactly one cycle per completed sequence.
  - busy is a registered state!=IDLE.
- enable=0:
  - State, counter and outputs freeze.
  - Resuming continues the same sequence with the same tgt and vtgt.
- Invariant: freq_code never increases unless ldo_code>=vtgt(freq_code) for the new code.
- Static inputs: step_size and v_guard are quasi-static and may change only while busy=0. settle_cycles is sampled at each settle entry.

Decomposition:
- Shared package dvfs_seq_pkg holds:
  - the state enum seq_state_t;
  - CODE_W and SETTLE_W defaults;
  - a saturating-add helper function.
- Sub-module settle_timer: a down-counter with load, enable and zero flag, reused by SETTLE_UP and SETTLE_DN.

Test Plan:
- Basic ramp up:
  - Stimulus: reset, then enable=1, step=4, settle=3, v_guard=2, freq_target=10.
  - Required: ldo_code goes 4, 8, 12, with each value held 5 cycles; freq_code=10 and done=1 appear 17 edges after the latch edge; busy then falls.
- Ramp down:
  - Stimulus: from the end of the ramp-up case, freq_target=3, step=4, settle=0.
  - Required: freq_code=3 on the edge after latch, before any ldo change; ldo_code goes 8, then 5 (clamped to vtgt=5); done pulses once.
- Saturation and step 0:
  - Stimulus: v_guard=15, target=250, step_size=0.
  - Required: vtgt=255; ldo_code increments by 1 per step with no wrap; freq_code=250 only after ldo_code=255.
- Target change mid-sequence:
  - Stimulus: freq_target changes 10 to 20 while in SETTLE_UP.
  - Required: the sequence completes to 10 with done; the next sequence starts from IDLE toward 20.
- Enable freeze:
  - Stimulus: deassert enable for 7 cycles in SETTLE_UP.
  - Required: ldo_code, freq_code, busy and the counter are all unchanged; total dwell is extended by exactly 7 cycles.
- Reset mid-sequence:
  - Stimulus: assert reset during RAMP_DN.
  - Required: on the next edge ldo_code=0, freq_code=0, busy=0, done=0; no done pulse is emitted.
